prsc_clk: RTL and testbench

//   Programmable power-of-two clock prescaler, clocked by clkIn.

---
 rtl/prsc_clk.sv | 88 ++++++++
 tb/tb_prsc_clk.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/prsc_clk.sv
`default_nettype none
// ============================================================================
//  Module   : prsc_clk
//  Purpose  : Programmable power-of-two clock prescaler. Divides clkIn by
//             N = 2^(psAct+1) and produces a 50% duty divided clock (clkOut),
//             a one-cycle strobe at the start of every output period (tick)
//             and the current position within the period (cnt).
//  Ports    : clkIn  - system clock, all flops rising edge
//             reset  - synchronous, active-high reset
//             en     - count enable (tie high if unused)
//             ps     - requested prescale select, applied only at wrap
//             clkOut - divided clock, registered
//             tick   - one-cycle strobe in the cnt==0 cycle after a wrap
//             cnt    - position in current period, 0..N-1
//  Revision : 1.0 - initial release
// ============================================================================
module prsc_clk #(
    parameter int CNT_WIDTH = 16,
    parameter int PS_WIDTH  = 4
) (
    input  logic                 clkIn,
    input  logic                 reset,
    input  logic                 en,
    input  logic [PS_WIDTH-1:0]  ps,
    output logic                 clkOut,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam int          c_ACT_W   = (CNT_WIDTH > 1) ? $clog2(CNT_WIDTH) : 1;
    localparam int unsigned c_MAX_SEL = CNT_WIDTH - 1;

    logic [c_ACT_W-1:0]   r_ps_act;
    logic [c_ACT_W-1:0]   w_ps_clamp;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_last_val;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_wrap;
    logic                 r_clk_out;
    logic                 r_tick;

    // Selects beyond the counter width would need a wider counter, so they
    // saturate to the largest ratio the counter can represent.
    always_comb begin
        w_ps_clamp = c_ACT_W'(ps);
        if (32'(ps) > c_MAX_SEL) begin
            w_ps_clamp = c_ACT_W'(c_MAX_SEL);
        end
    end

    // N-1 is a mask of ones in bits 0..psAct.
    always_comb begin
        w_last_val = '0;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            w_last_val[i] = (32'(r_ps_act) >= 32'(i));
        end
    end

    assign w_wrap    = (r_cnt == w_last_val);
    assign w_cnt_nxt = w_wrap ? '0 : (r_cnt + CNT_WIDTH'(1));

    // The select only updates at wrap (or reset), so a period in progress
    // always finishes with its original ratio and no runt pulse appears.
    // clkOut is taken from the next count so it stays aligned with cnt.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_ps_act  <= w_ps_clamp;
        end else if (en) begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_cnt_nxt[r_ps_act];
            r_tick    <= w_wrap;
            if (w_wrap) begin
                r_ps_act <= w_ps_clamp;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign cnt    = r_cnt;
    assign clkOut = r_clk_out;
    assign tick   = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_prsc_clk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prsc_clk
//  Purpose  : Self-checking bench for prsc_clk. A table of per-cycle
//             {inputs, expected outputs} records covers reset, ratio
//             changes, enable hold and reset mid-period; hand-written
//             sequences cover the full 65536-cycle period and select clamp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prsc_clk;

    logic        clkIn = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  ps;
    logic        clkOut;
    logic        tick;
    logic [15:0] cnt;

    // Second instance with a narrow counter so selects above the limit clamp.
    logic        clkOut_n;
    logic        tick_n;
    logic [3:0]  cnt_n;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  ps;
        logic [15:0] cnt;
        logic        clk;
        logic        tick;
    } vec_t;

    vec_t vq[$];

    prsc_clk #(.CNT_WIDTH(16), .PS_WIDTH(4)) dut (
        .clkIn  (clkIn),
        .reset  (reset),
        .en     (en),
        .ps     (ps),
        .clkOut (clkOut),
        .tick   (tick),
        .cnt    (cnt)
    );

    prsc_clk #(.CNT_WIDTH(4), .PS_WIDTH(4)) dut_n (
        .clkIn  (clkIn),
        .reset  (reset),
        .en     (en),
        .ps     (ps),
        .clkOut (clkOut_n),
        .tick   (tick_n),
        .cnt    (cnt_n)
    );

    always #5 clkIn = ~clkIn;

    function automatic void add(input int r, input int e, input int p,
                                input int c, input int ck, input int t);
        vec_t v;
        v.rst  = r[0];
        v.en   = e[0];
        v.ps   = p[3:0];
        v.cnt  = c[15:0];
        v.clk  = ck[0];
        v.tick = t[0];
        vq.push_back(v);
    endfunction

    initial begin
        bit ok;
        // ---- reset, ps=0 ----
        add(1,1,0, 0,0,0);
        add(1,1,0, 0,0,0);
        add(0,1,0, 1,1,0);
        add(0,1,0, 0,0,1);
        add(0,1,0, 1,1,0);
        add(0,1,0, 0,0,1);
        // ---- ps=2 requested mid-period: old ratio finishes first ----
        add(0,1,2, 1,1,0);
        add(0,1,2, 0,0,1);
        for (int c = 1; c < 8; c++) add(0,1,2, c, (c >= 4) ? 1 : 0, 0);
        add(0,1,2, 0,0,1);
        for (int c = 1; c < 4; c++) add(0,1,2, c, 0, 0);
        // ---- enable low at cnt=3 ----
        for (int k = 0; k < 5; k++) add(0,0,2, 3,0,0);
        add(0,1,2, 4,1,0);
        add(0,1,2, 5,1,0);
        add(0,0,2, 5,1,0);
        add(0,1,2, 6,1,0);
        // ---- reset at cnt=6, with en low: reset wins ----
        add(1,0,2, 0,0,0);
        // ---- ps=1 loaded in reset, ps=3 requested at cnt=1 ----
        add(1,1,1, 0,0,0);
        add(0,1,1, 1,0,0);
        add(0,1,3, 2,1,0);
        add(0,1,3, 3,1,0);
        add(0,1,3, 0,0,1);
        for (int c = 1; c < 16; c++) add(0,1,3, c, (c >= 8) ? 1 : 0, 0);
        add(0,1,3, 0,0,1);
        add(0,1,3, 1,0,0);

        foreach (vq[i]) begin
            reset = vq[i].rst;
            en    = vq[i].en;
            ps    = vq[i].ps;
            @(posedge clkIn);
            #1;
            n_vec++;
            if (cnt !== vq[i].cnt || clkOut !== vq[i].clk || tick !== vq[i].tick) begin
                n_err++;
                $display("FAIL vec%0d: got cnt=%0d clkOut=%b tick=%b, expected cnt=%0d clkOut=%b tick=%b",
                         i, cnt, clkOut, tick, vq[i].cnt, vq[i].clk, vq[i].tick);
            end
        end

        // ---- ps=15: full 65536-cycle period ----
        reset = 1'b1; en = 1'b1; ps = 4'd15;
        @(posedge clkIn);
        #1;
        reset = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 65537 && ok; k++) begin
            int          ec;
            logic        eclk;
            logic        etick;
            ec    = k % 65536;
            eclk  = (ec >= 32768);
            etick = (ec == 0);
            @(posedge clkIn);
            #1;
            n_vec++;
            if (cnt !== ec[15:0] || clkOut !== eclk || tick !== etick) begin
                n_err++;
                ok = 1'b0;
                $display("FAIL ps15 step%0d: got cnt=%0d clkOut=%b tick=%b, expected cnt=%0d clkOut=%b tick=%b",
                         k, cnt, clkOut, tick, ec, eclk, etick);
            end
        end

        // ---- clamp: narrow counter, ps=9 behaves as ps=3 (N=16) ----
        reset = 1'b1; en = 1'b1; ps = 4'd9;
        @(posedge clkIn);
        #1;
        n_vec++;
        if (cnt_n !== 4'd0 || clkOut_n !== 1'b0 || tick_n !== 1'b0) begin
            n_err++;
            $display("FAIL clamp reset: got cnt=%0d clkOut=%b tick=%b, expected cnt=0 clkOut=0 tick=0",
                     cnt_n, clkOut_n, tick_n);
        end
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            int   ec;
            logic eclk;
            logic etick;
            ec    = k % 16;
            eclk  = (ec >= 8);
            etick = (ec == 0);
            @(posedge clkIn);
            #1;
            n_vec++;
            if (cnt_n !== ec[3:0] || clkOut_n !== eclk || tick_n !== etick) begin
                n_err++;
                $display("FAIL clamp step%0d: got cnt=%0d clkOut=%b tick=%b, expected cnt=%0d clkOut=%b tick=%b",
                         k, cnt_n, clkOut_n, tick_n, ec, eclk, etick);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
